sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sqrt_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: four requesters share one external square-root unit.
// Channels are served round-robin. A one-entry cache holds the last radicand
// and its root so that a repeated radicand completes without restarting the
// unit. The unit's ready strobe is ignored for a fixed settle window after a
// new radicand is issued. A wait that runs too long aborts with 16'hFFFF.
module sqrt_arbiter #(
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 31
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [3:0]   req,
  input  logic [127:0] operand,
  output logic [3:0]   done,
  output logic [15:0]  result,
  output logic         busy,
  output logic         timeout_err,
  output logic [31:0]  sqrt_num_out,
  input  logic [15:0]  sqrt_result_in,
  input  logic         sqrt_ready_in
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   sel_q, sel_d;          // channel currently being served
  logic [1:0]   last_q, last_d;        // last channel that completed
  logic [31:0]  num_q, num_d;          // radicand driven to the unit
  logic [31:0]  last_op_q, last_op_d;  // cached radicand
  logic         cache_vld_q, cache_vld_d;
  logic [15:0]  cache_res_q, cache_res_d;
  logic [15:0]  result_q, result_d;
  logic [3:0]   done_q, done_d;
  logic         busy_q, busy_d;
  logic         tmo_err_q, tmo_err_d;
  logic [2:0]   settle_q, settle_d;
  logic [5:0]   tmo_cnt_q, tmo_cnt_d;

  logic         grant_vld_s;
  logic [1:0]   grant_idx_s;
  logic [1:0]   cand_s;
  logic [31:0]  sel_op_s;
  logic         hit_s;

  // Round-robin pick: scan from last+1 upward, nearest requester wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 2'd0;
    cand_s      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand_s = last_q + 2'(k + 1);
      if (req[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Only the granted channel's radicand is looked at; compare it to the cache.
  always_comb begin
    sel_op_s = 32'd0;
    case (grant_idx_s)
      2'd0:    sel_op_s = operand[31:0];
      2'd1:    sel_op_s = operand[63:32];
      2'd2:    sel_op_s = operand[95:64];
      2'd3:    sel_op_s = operand[127:96];
      default: sel_op_s = 32'd0;
    endcase
    hit_s = cache_vld_q && (sel_op_s == last_op_q);
  end

  // Next-state and datapath decisions for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    num_d       = num_q;
    last_op_d   = last_op_q;
    cache_vld_d = cache_vld_q;
    cache_res_d = cache_res_q;
    result_d    = result_q;
    done_d      = 4'b0000;
    tmo_err_d   = 1'b0;
    settle_d    = settle_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          sel_d = grant_idx_s;
          if (hit_s) begin
            // Same radicand as last time: reuse the cached root directly.
            state_d  = ST_DONE;
            result_d = cache_res_q;
            done_d   = 4'b0001 << grant_idx_s;
          end else begin
            state_d     = ST_SETTLE;
            num_d       = sel_op_s;
            last_op_d   = sel_op_s;
            cache_vld_d = 1'b0;
            settle_d    = 3'(SETTLE_CYC);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q <= 3'd1) begin
          state_d   = ST_WAIT;
          settle_d  = 3'd0;
          tmo_cnt_d = 6'd0;
        end else begin
          settle_d = settle_q - 3'd1;
        end
      end
      ST_WAIT: begin
        if (sqrt_ready_in) begin
          state_d     = ST_DONE;
          result_d    = sqrt_result_in;
          cache_res_d = sqrt_result_in;
          cache_vld_d = 1'b1;
          done_d      = 4'b0001 << sel_q;
        end else if (tmo_cnt_q == 6'(TIMEOUT_CYC - 1)) begin
          // Counter reaches the limit this cycle: abort with the error code.
          state_d     = ST_DONE;
          tmo_cnt_d   = tmo_cnt_q + 6'd1;
          result_d    = 16'hFFFF;
          cache_vld_d = 1'b0;
          tmo_err_d   = 1'b1;
          done_d      = 4'b0001 << sel_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 6'd1;
        end
      end
      ST_DONE: begin
        last_d  = sel_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 2'd0;
      last_q      <= 2'd3;
      num_q       <= 32'd0;
      last_op_q   <= 32'd0;
      cache_vld_q <= 1'b0;
      cache_res_q <= 16'd0;
      result_q    <= 16'd0;
      done_q      <= 4'b0000;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      settle_q    <= 3'd0;
      tmo_cnt_q   <= 6'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      num_q       <= num_d;
      last_op_q   <= last_op_d;
      cache_vld_q <= cache_vld_d;
      cache_res_q <= cache_res_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tmo_err_q   <= tmo_err_d;
      settle_q    <= settle_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign done         = done_q;
  assign result       = result_q;
  assign busy         = busy_q;
  assign timeout_err  = tmo_err_q;
  assign sqrt_num_out = num_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural square-root unit that
// holds ready at a bench-controlled level and returns floor(sqrt(num)).
module tb_sqrt_arbiter;

  logic         clk;
  logic         n_rst;
  logic [3:0]   req;
  logic [127:0] operand;
  logic [3:0]   done;
  logic [15:0]  result;
  logic         busy;
  logic         timeout_err;
  logic [31:0]  sqrt_num_out;
  logic [15:0]  sqrt_result_in;
  logic         sqrt_ready_in;
  logic         ready_en;

  int total = 0;
  int bad   = 0;
  int cyc;

  sqrt_arbiter #(.SETTLE_CYC(3), .TIMEOUT_CYC(31)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .req            (req),
    .operand        (operand),
    .done           (done),
    .result         (result),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .sqrt_num_out   (sqrt_num_out),
    .sqrt_result_in (sqrt_result_in),
    .sqrt_ready_in  (sqrt_ready_in)
  );

  // Behavioural square-root unit.
  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [63:0] op;
    logic [63:0] res;
    logic [63:0] one;
    op  = {32'd0, v};
    res = 64'd0;
    one = 64'd1 << 30;
    while (one > op) one = one >> 2;
    while (one != 64'd0) begin
      if (op >= res + one) begin
        op  = op - res - one;
        res = (res >> 1) + one;
      end else begin
        res = res >> 1;
      end
      one = one >> 2;
    end
    return res[15:0];
  endfunction

  assign sqrt_result_in = isqrt(sqrt_num_out);
  assign sqrt_ready_in  = ready_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until a done pulse is seen on a falling edge.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 4'b0000 && n < 200);
    check_eq("done_seen", {31'd0, done != 4'b0000}, 32'd1);
  endtask

  task automatic set_op(input int ch, input logic [31:0] v);
    operand[ch*32 +: 32] = v;
  endtask

  logic [3:0]  ord_m [4];
  logic [15:0] ord_r [4];

  initial begin
    ord_m = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    ord_r = '{16'd4, 16'd1, 16'd2, 16'd3};
    n_rst    = 1'b0;
    req      = 4'b0000;
    operand  = 128'd0;
    ready_en = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_done",   {28'd0, done}, 32'd0);
    check_eq("rst_result", {16'd0, result}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_tmo",    {31'd0, timeout_err}, 32'd0);
    check_eq("rst_num",    sqrt_num_out, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // First operation on channel 0: miss, 1 select + 3 settle + 1 wait edge.
    set_op(0, 32'd144);
    req = 4'b0001;
    @(negedge clk);
    check_eq("busy_op", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check_eq("miss_lat",  32'(cyc + 1), 32'd5);
    check_eq("ch0_done",  {28'd0, done}, 32'h1);
    check_eq("ch0_res",   {16'd0, result}, 32'd12);
    check_eq("ch0_tmo",   {31'd0, timeout_err}, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    check_eq("one_pulse", {28'd0, done}, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);

    // Same radicand on channel 2: cache hit, done right after select edge.
    set_op(2, 32'd144);
    req = 4'b0100;
    wait_done(cyc);
    check_eq("hit_lat",  32'(cyc), 32'd1);
    check_eq("hit_done", {28'd0, done}, 32'h4);
    check_eq("hit_res",  {16'd0, result}, 32'd12);
    check_eq("hit_num",  sqrt_num_out, 32'd144);
    req = 4'b0000;
    @(negedge clk);

    // All four request after channel 2 was served: order 3,0,1,2.
    set_op(0, 32'd1);
    set_op(1, 32'd4);
    set_op(2, 32'd9);
    set_op(3, 32'd16);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc);
      check_eq("rr_done", {28'd0, done}, {28'd0, ord_m[i]});
      check_eq("rr_res",  {16'd0, result}, {16'd0, ord_r[i]});
      if (i == 1) check_eq("b2b_lat", 32'(cyc), 32'd6);
      req = req & ~done;
    end
    @(negedge clk);

    // Unit never ready: abort after 1 + 3 settle + 31 wait edges.
    ready_en = 1'b0;
    set_op(1, 32'd25);
    req = 4'b0010;
    wait_done(cyc);
    check_eq("tmo_lat",  32'(cyc), 32'd35);
    check_eq("tmo_done", {28'd0, done}, 32'h2);
    check_eq("tmo_flag", {31'd0, timeout_err}, 32'd1);
    check_eq("tmo_res",  {16'd0, result}, 32'hFFFF);
    req = 4'b0000;
    ready_en = 1'b1;
    @(negedge clk);
    check_eq("tmo_pulse", {31'd0, timeout_err}, 32'd0);
    req = 4'b0010;
    wait_done(cyc);
    check_eq("retry_miss_lat", 32'(cyc), 32'd5);
    check_eq("retry_res", {16'd0, result}, 32'd5);
    req = 4'b0000;
    @(negedge clk);

    // Reset while waiting on the unit.
    ready_en = 1'b0;
    set_op(0, 32'd49);
    req = 4'b0001;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    check_eq("pre_rst_num",  sqrt_num_out, 32'd49);
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_res",  {16'd0, result}, 32'd0);
    check_eq("mid_rst_num",  sqrt_num_out, 32'd0);
    check_eq("mid_rst_tmo",  {31'd0, timeout_err}, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("mid_rst_done", {28'd0, done}, 32'd0);
    ready_en = 1'b1;
    n_rst = 1'b1;
    wait_done(cyc);
    check_eq("post_rst_lat",  32'(cyc), 32'd5);
    check_eq("post_rst_done", {28'd0, done}, 32'h1);
    check_eq("post_rst_res",  {16'd0, result}, 32'd7);
    req = 4'b0000;
    @(negedge clk);

    // Extremes of the radicand range.
    set_op(3, 32'hFFFFFFFF);
    req = 4'b1000;
    wait_done(cyc);
    check_eq("max_done", {28'd0, done}, 32'h8);
    check_eq("max_res",  {16'd0, result}, 32'hFFFF);
    check_eq("max_tmo",  {31'd0, timeout_err}, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    set_op(2, 32'd0);
    req = 4'b0100;
    wait_done(cyc);
    check_eq("zero_done", {28'd0, done}, 32'h4);
    check_eq("zero_res",  {16'd0, result}, 32'd0);
    req = 4'b0000;
    @(negedge clk);

    // Unselected operands must not disturb a hit on channel 1.
    set_op(1, 32'd0);
    set_op(0, 32'd7);
    req = 4'b0010;
    wait_done(cyc);
    check_eq("iso_lat",  32'(cyc), 32'd1);
    check_eq("iso_done", {28'd0, done}, 32'h2);
    check_eq("iso_res",  {16'd0, result}, 32'd0);
    req = 4'b0000;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
